// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit with a small credit-controlled instruction buffer
//
// Issues sequential 32-bit reads to instruction memory. Each response is captured
// one cycle after issue into a DEPTH-entry FIFO of {pc, instr}, which feeds decode.
// Issue is credit-limited so the buffer can never overflow. A redirect reloads the
// pc, flushes the buffer and squashes any in-flight response.
//
// Optional feature macro: IF_FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect_pc raises fetch_fault and halts issue until
//               the next aligned redirect, which clears the fault
//   undefined : fetch_fault is tied 0 and redirect_pc[1:0] is ignored
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   DEPTH           instruction buffer entries (2..4)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   im_en/im_addr   memory read enable / address (im_addr is the pc register)
//   im_addrout      memory echo of the address issued one cycle earlier
//   im_dout         memory instruction word, valid one cycle after issue
//   im_stall        memory stall: no capture and no issue while high
//   redirect_valid  branch/jump redirect strobe, target in redirect_pc
//   out_valid/out_ready/out_pc/out_instr   buffer head toward decode
//   fetch_fault     misaligned-redirect fault flag

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_en,
    output logic [31:0] im_addr,
    input  logic [31:0] im_addrout,
    input  logic [31:0] im_dout,
    input  logic        im_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [1:0] LAST    = 2'(DEPTH - 1);

    logic [31:0] r_pc;
    logic        r_pending;
    logic [2:0]  r_count;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [31:0] r_buf_pc    [4];
    logic [31:0] r_buf_instr [4];

    logic        w_pop;
    logic        w_capture;
    logic        w_fault;
    logic [2:0]  w_credit;
    logic [31:0] w_redirect_pc;
    logic [1:0]  w_wptr_nxt;
    logic [1:0]  w_rptr_nxt;

`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic r_fault;
    logic w_misaligned;

    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_pc = redirect_pc;
    assign w_fault       = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= w_misaligned;
        end
    end
`else
    logic w_unused;

    assign w_unused      = ^redirect_pc[1:0];
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_fault       = 1'b0;
`endif

    assign fetch_fault = w_fault;
    assign out_valid   = (r_count != 3'd0);
    assign out_pc      = r_buf_pc[r_rptr];
    assign out_instr   = r_buf_instr[r_rptr];
    assign im_addr     = r_pc;

    assign w_pop = out_valid & out_ready;

    // Slots already committed: buffered entries plus the in-flight read, minus
    // the entry leaving this cycle. pop implies count >= 1, so no underflow.
    assign w_credit = r_count + {2'b00, r_pending} - {2'b00, w_pop};

    assign im_en = ~rst & ~redirect_valid & ~im_stall & ~w_fault & (w_credit < DEPTH_C);

    // A response arriving in a redirect cycle belongs to the old path: squash it.
    assign w_capture = r_pending & ~im_stall & ~redirect_valid;

    assign w_wptr_nxt = (r_wptr == LAST) ? 2'd0 : r_wptr + 2'd1;
    assign w_rptr_nxt = (r_rptr == LAST) ? 2'd0 : r_rptr + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pending <= 1'b0;
            r_count   <= 3'd0;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
        end else if (redirect_valid) begin
            r_pc      <= w_redirect_pc;
            r_pending <= 1'b0;
            r_count   <= 3'd0;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
        end else begin
            if (im_en) begin
                r_pc <= r_pc + 32'd4;
            end
            // A stalled response stays in flight; otherwise it is consumed now.
            if (!im_stall) begin
                r_pending <= im_en;
            end
            if (w_capture) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf_pc[r_wptr]    <= im_addrout;
            r_buf_instr[r_wptr] <= im_dout;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_capture && !w_pop && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch

module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        im_en;
    logic [31:0] im_addr;
    logic [31:0] im_addrout;
    logic [31:0] im_dout;
    logic        im_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_en          (im_en),
        .im_addr        (im_addr),
        .im_addrout     (im_addrout),
        .im_dout        (im_dout),
        .im_stall       (im_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // One-cycle-latency memory; holds its response while no read is issued.
    always_ff @(posedge clk) begin
        if (im_en) begin
            im_addrout <= im_addr;
            im_dout    <= word(im_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        out_ready      = rdy;
        im_stall       = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b1;
        out_ready      = rdy;
        im_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        im_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("rst_im_en", im_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        check("rst_pc", im_addr, 32'h0);
        @(posedge clk);
        #1;
        check("rst_out_valid2", out_valid, 1'b0);

        // Fill and streaming throughput
        do_reset(1'b1);
        check("t1c0_im_en", im_en, 1'b1);
        check("t1c0_addr", im_addr, 32'h0);
        check("t1c0_valid", out_valid, 1'b0);
        cyc(1, 0, 0, 0);
        check("t1c1_im_en", im_en, 1'b1);
        check("t1c1_addr", im_addr, 32'h4);
        check("t1c1_valid", out_valid, 1'b0);
        cyc(1, 0, 0, 0);
        check("t1c2_valid", out_valid, 1'b1);
        check("t1c2_pc", out_pc, 32'h0);
        check("t1c2_instr", out_instr, 32'h11);
        cyc(1, 0, 0, 0);
        check("t1c3_pc", out_pc, 32'h4);
        check("t1c3_instr", out_instr, 32'h22);
        cyc(1, 0, 0, 0);
        check("t1c4_pc", out_pc, 32'h8);
        check("t1c4_instr", out_instr, 32'h33);

        // Backpressure: buffer fills to DEPTH and issue stops
        do_reset(1'b0);
        check("t2c0_im_en", im_en, 1'b1);
        cyc(0, 0, 0, 0);
        check("t2c1_im_en", im_en, 1'b1);
        cyc(0, 0, 0, 0);
        check("t2c2_im_en", im_en, 1'b0);
        check("t2c2_pc", out_pc, 32'h0);
        cyc(0, 0, 0, 0);
        check("t2c3_im_en", im_en, 1'b0);
        check("t2c3_count", 32'(dut.r_count), 32'd2);
        check("t2c3_pc", out_pc, 32'h0);
        check("t2c3_instr", out_instr, 32'h11);
        cyc(0, 0, 0, 0);
        check("t2c4_im_en", im_en, 1'b0);
        check("t2c4_pc", out_pc, 32'h0);
        cyc(1, 0, 0, 0);
        check("t2c5_pc", out_pc, 32'h0);
        check("t2c5_im_en", im_en, 1'b1);
        check("t2c5_addr", im_addr, 32'h8);
        cyc(1, 0, 0, 0);
        check("t2c6_pc", out_pc, 32'h4);
        check("t2c6_valid", out_valid, 1'b1);
        cyc(1, 0, 0, 0);
        check("t2c7_pc", out_pc, 32'h8);
        check("t2c7_instr", out_instr, 32'h33);

        // Redirect squashes the in-flight read to 0x8
        do_reset(1'b1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t3c2_pc", out_pc, 32'h0);
        cyc(1, 0, 1, 32'h40);
        check("t3c3_pc", out_pc, 32'h4);
        check("t3c3_pending", 32'(dut.r_pending), 32'd1);
        check("t3c3_im_en", im_en, 1'b0);
        cyc(1, 0, 0, 0);
        check("t3c4_valid", out_valid, 1'b0);
        check("t3c4_im_en", im_en, 1'b1);
        check("t3c4_addr", im_addr, 32'h40);
        cyc(1, 0, 0, 0);
        check("t3c5_valid", out_valid, 1'b0);
        check("t3c5_addr", im_addr, 32'h44);
        cyc(1, 0, 0, 0);
        check("t3c6_pc", out_pc, 32'h40);
        check("t3c6_instr", out_instr, 32'h121);
        cyc(1, 0, 0, 0);
        check("t3c7_pc", out_pc, 32'h44);
        check("t3c7_instr", out_instr, 32'h132);

        // Memory stall for 3 cycles mid-stream
        do_reset(1'b1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t4c2_pc", out_pc, 32'h0);
        cyc(1, 1, 0, 0);
        check("t4c3_pc", out_pc, 32'h4);
        check("t4c3_im_en", im_en, 1'b0);
        cyc(1, 1, 0, 0);
        check("t4c4_valid", out_valid, 1'b0);
        check("t4c4_im_en", im_en, 1'b0);
        check("t4c4_addr", im_addr, 32'hC);
        cyc(1, 1, 0, 0);
        check("t4c5_im_en", im_en, 1'b0);
        check("t4c5_addr", im_addr, 32'hC);
        cyc(1, 0, 0, 0);
        check("t4c6_im_en", im_en, 1'b1);
        check("t4c6_addr", im_addr, 32'hC);
        check("t4c6_valid", out_valid, 1'b0);
        cyc(1, 0, 0, 0);
        check("t4c7_pc", out_pc, 32'h8);
        check("t4c7_instr", out_instr, 32'h33);
        cyc(1, 0, 0, 0);
        check("t4c8_pc", out_pc, 32'hC);
        check("t4c8_instr", out_instr, 32'h44);
        cyc(1, 0, 0, 0);
        check("t4c9_pc", out_pc, 32'h10);
        check("t4c9_instr", out_instr, 32'h55);

        // Asynchronous reset with a full buffer
        do_reset(1'b0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t5_full_valid", out_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        check("t5_async_im_en", im_en, 1'b0);
        check("t5_async_pc", im_addr, 32'h0);
        check("t5_async_count", 32'(dut.r_count), 32'd0);
        do_reset(1'b1);
        check("t5c0_im_en", im_en, 1'b1);
        check("t5c0_addr", im_addr, 32'h0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t5c2_pc", out_pc, 32'h0);
        check("t5c2_instr", out_instr, 32'h11);

        // pc wraps from 0xFFFF_FFFC to 0
        cyc(1, 0, 1, 32'hFFFF_FFFC);
        check("t6c3_im_en", im_en, 1'b0);
        cyc(1, 0, 0, 0);
        check("t6c4_addr", im_addr, 32'hFFFF_FFFC);
        check("t6c4_im_en", im_en, 1'b1);
        cyc(1, 0, 0, 0);
        check("t6c5_addr", im_addr, 32'h0);
        cyc(1, 0, 0, 0);
        check("t6c6_pc", out_pc, 32'hFFFF_FFFC);
        check("t6c6_instr", out_instr, 32'h4000_0000);
        cyc(1, 0, 0, 0);
        check("t6c7_pc", out_pc, 32'h0);
        check("t6c7_instr", out_instr, 32'h11);

        // Misaligned redirect
        cyc(1, 0, 1, 32'h42);
`ifdef IF_FETCH_ALIGN_CHECK_EN
        cyc(1, 0, 0, 0);
        check("t7c9_fault", fetch_fault, 1'b1);
        check("t7c9_im_en", im_en, 1'b0);
        check("t7c9_valid", out_valid, 1'b0);
        cyc(1, 0, 0, 0);
        check("t7c10_fault", fetch_fault, 1'b1);
        check("t7c10_im_en", im_en, 1'b0);
        cyc(1, 0, 1, 32'h80);
        check("t7c11_im_en", im_en, 1'b0);
        cyc(1, 0, 0, 0);
        check("t7c12_fault", fetch_fault, 1'b0);
        check("t7c12_im_en", im_en, 1'b1);
        check("t7c12_addr", im_addr, 32'h80);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t7c14_pc", out_pc, 32'h80);
        check("t7c14_instr", out_instr, 32'h231);
`else
        cyc(1, 0, 0, 0);
        check("t7c9_fault", fetch_fault, 1'b0);
        check("t7c9_im_en", im_en, 1'b1);
        check("t7c9_addr", im_addr, 32'h40);
        cyc(1, 0, 0, 0);
        check("t7c10_addr", im_addr, 32'h44);
        cyc(1, 0, 0, 0);
        check("t7c11_pc", out_pc, 32'h40);
        check("t7c11_instr", out_instr, 32'h121);
        check("t7c11_fault", fetch_fault, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
